// File: rtl/dds_phase_addr_gen_if.sv
// Configuration handshake and RAM address bus of the DDS phase-to-address generator.
// The generator sits on the slave modport; the configuring/consuming side uses master.
interface dds_phase_addr_gen_if #(
  parameter int unsigned PHASE_WIDTH = 32,
  parameter int unsigned SEG_BITS    = 10,
  parameter int unsigned ADDR_WIDTH  = 12
);
  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [PHASE_WIDTH-1:0] cfg_ftw;
  logic [SEG_BITS-1:0]    cfg_poff;
  logic [1:0]             cfg_wave;
  logic [ADDR_WIDTH-1:0]  addr;
  logic                   addr_valid;
  logic                   wrn;
  logic                   wrap;

  modport master (
    output cfg_valid, cfg_ftw, cfg_poff, cfg_wave,
    input  cfg_ready, addr, addr_valid, wrn, wrap
  );

  modport slave (
    input  cfg_valid, cfg_ftw, cfg_poff, cfg_wave,
    output cfg_ready, addr, addr_valid, wrn, wrap
  );
endinterface

// File: rtl/dds_phase_addr_gen.sv
// DDS phase accumulator producing waveform RAM read addresses, with a shadowed
// configuration that is swapped in only at an accumulator wrap.
module dds_phase_addr_gen #(
  parameter int unsigned PHASE_WIDTH = 32,
  parameter int unsigned SEG_BITS    = 10,
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned NUM_WAVES   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  dds_phase_addr_gen_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRun, StPend} state_e;

  typedef struct packed {
    logic [PHASE_WIDTH-1:0] ftw;
    logic [SEG_BITS-1:0]    poff;
    logic [1:0]             wave;
  } cfg_t;

  state_e                 state_q, state_d;
  logic [PHASE_WIDTH-1:0] acc_q, acc_d;
  cfg_t                   act_q, act_d;
  cfg_t                   shd_q, shd_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   addr_valid_q, addr_valid_d;

  cfg_t                   cfg_in;
  logic                   cfg_ready;
  logic                   accept;
  logic                   wrap;
  logic [PHASE_WIDTH:0]   sum;
  logic [SEG_BITS-1:0]    index;
  logic [1:0]             wave_eff;
  logic [ADDR_WIDTH-1:0]  addr_calc;

  assign cfg_in = '{ftw: bus.cfg_ftw, poff: bus.cfg_poff, wave: bus.cfg_wave};

  // Address is always formed from the pre-increment accumulator and the active config.
  always_comb begin
    sum       = {1'b0, acc_q} + {1'b0, act_q.ftw};
    index     = acc_q[PHASE_WIDTH-1 -: SEG_BITS] + act_q.poff;
    wave_eff  = (32'(act_q.wave) < NUM_WAVES) ? act_q.wave : 2'd0;
    addr_calc = (ADDR_WIDTH'(wave_eff) << SEG_BITS) | ADDR_WIDTH'(index);
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    act_d        = act_q;
    shd_d        = shd_q;
    addr_d       = addr_q;
    addr_valid_d = 1'b0;
    wrap         = 1'b0;
    cfg_ready    = (state_q != StPend);
    accept       = bus.cfg_valid & cfg_ready;

    case (state_q)
      StIdle: begin
        acc_d = '0;
        if (accept) begin
          act_d   = cfg_in;
          state_d = StRun;
        end
      end
      StRun: begin
        if (en) begin
          acc_d        = sum[PHASE_WIDTH-1:0];
          wrap         = sum[PHASE_WIDTH];
          addr_d       = addr_calc;
          addr_valid_d = 1'b1;
        end
        if (accept) begin
          shd_d   = cfg_in;
          state_d = StPend;
        end
      end
      StPend: begin
        if (en) begin
          acc_d        = sum[PHASE_WIDTH-1:0];
          wrap         = sum[PHASE_WIDTH];
          addr_d       = addr_calc;
          addr_valid_d = 1'b1;
          // A zero step never carries, so swap on the first enabled edge instead.
          if (sum[PHASE_WIDTH] || (act_q.ftw == '0)) begin
            act_d   = shd_q;
            state_d = StRun;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      acc_q        <= '0;
      act_q        <= '0;
      shd_q        <= '0;
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      act_q        <= act_d;
      shd_q        <= shd_d;
      addr_q       <= addr_d;
      addr_valid_q <= addr_valid_d;
    end
  end

  assign bus.cfg_ready  = cfg_ready;
  assign bus.addr       = addr_q;
  assign bus.addr_valid = addr_valid_q;
  assign bus.wrn        = 1'b0;
  assign bus.wrap       = wrap;

endmodule

// File: tb/tb_dds_phase_addr_gen.sv
// Directed and randomized checks of dds_phase_addr_gen against an arithmetic reference model.
module tb_dds_phase_addr_gen;

  logic clk = 1'b0;
  logic rst;
  logic en;

  always #5 clk = ~clk;

  dds_phase_addr_gen_if #(.PHASE_WIDTH(32), .SEG_BITS(10), .ADDR_WIDTH(12)) bus ();

  dds_phase_addr_gen #(
    .PHASE_WIDTH(32),
    .SEG_BITS(10),
    .ADDR_WIDTH(12),
    .NUM_WAVES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: plain integers, a "started" flag and a "config waiting" flag.
  bit              m_known = 0;
  bit              m_started, m_waiting, m_valid;
  longint unsigned m_acc, a_ftw, s_ftw;
  int              a_poff, a_wave, s_poff, s_wave, m_addr;

  localparam longint unsigned Modulus = 64'h1_0000_0000;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_carry();
    return (m_acc + a_ftw) >= Modulus;
  endfunction

  function automatic int m_sample_addr();
    int w;
    w = (a_wave < 3) ? a_wave : 0;
    return w * 1024 + int'(((m_acc / (1 << 22)) + longint'(a_poff)) % 1024);
  endfunction

  task automatic model_edge(input bit r, input bit e, input bit v, input longint unsigned f,
                            input int p, input int w);
    bit took, c;
    if (r) begin
      m_started = 0; m_waiting = 0; m_valid = 0; m_acc = 0; m_addr = 0;
      a_ftw = 0; a_poff = 0; a_wave = 0; s_ftw = 0; s_poff = 0; s_wave = 0;
      m_known = 1;
    end else if (!m_started) begin
      m_valid = 0;
      if (v) begin
        a_ftw = f; a_poff = p; a_wave = w; m_started = 1;
      end
    end else begin
      took = v && !m_waiting;
      if (e) begin
        c       = m_carry();
        m_addr  = m_sample_addr();
        m_acc   = (m_acc + a_ftw) % Modulus;
        m_valid = 1;
        if (m_waiting && (c || a_ftw == 0)) begin
          a_ftw = s_ftw; a_poff = s_poff; a_wave = s_wave; m_waiting = 0;
        end
      end else begin
        m_valid = 0;
      end
      if (took) begin
        s_ftw = f; s_poff = p; s_wave = w; m_waiting = 1;
      end
    end
  endtask

  // Called at a falling edge; returns at the next falling edge with outputs checked.
  task automatic cycle(input bit r, input bit e, input bit v, input logic [31:0] f,
                       input logic [9:0] p, input logic [1:0] w);
    rst = r; en = e;
    bus.cfg_valid = v; bus.cfg_ftw = f; bus.cfg_poff = p; bus.cfg_wave = w;
    #1;
    if (m_known) begin
      chk("wrap", bus.wrap, m_started && e && m_carry());
      chk("cfg_ready_pre", bus.cfg_ready, !m_waiting);
    end
    @(posedge clk);
    model_edge(r, e, v, longint'(f), int'(p), int'(w));
    @(negedge clk);
    chk("addr", bus.addr, m_addr);
    chk("addr_valid", bus.addr_valid, m_valid);
    chk("cfg_ready", bus.cfg_ready, !m_waiting);
    chk("wrn", bus.wrn, 0);
  endtask

  task automatic idle_run(input int n);
    for (int i = 0; i < n; i++) cycle(0, 1, 0, 32'h0, 10'h0, 2'd0);
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, 32'h0, 10'h0, 2'd0);
  endtask

  initial begin
    logic [11:0] held;
    rst = 1; en = 0;
    bus.cfg_valid = 0; bus.cfg_ftw = '0; bus.cfg_poff = '0; bus.cfg_wave = '0;
    @(negedge clk);
    do_reset();
    do_reset();
    chk("reset_addr", bus.addr, 0);
    chk("reset_valid", bus.addr_valid, 0);
    chk("reset_ready", bus.cfg_ready, 1);

    // Quarter-cycle step on wave 0.
    cycle(0, 1, 1, 32'h4000_0000, 10'd0, 2'd0);
    chk("first_cfg_valid", bus.addr_valid, 0);
    for (int k = 0; k < 8; k++) begin
      idle_run(1);
      chk("q_step_addr", bus.addr, (k % 4) * 256);
    end

    // Wave 2 with offset, then out-of-range wave 3.
    do_reset();
    cycle(0, 1, 1, 32'h4000_0000, 10'd16, 2'd2);
    for (int k = 0; k < 8; k++) begin
      idle_run(1);
      chk("wave2_addr", bus.addr, 2064 + (k % 4) * 256);
    end
    do_reset();
    cycle(0, 1, 1, 32'h4000_0000, 10'd0, 2'd3);
    for (int k = 0; k < 4; k++) begin
      idle_run(1);
      chk("wave3_addr", bus.addr, k * 256);
    end

    // Reconfigure mid-period: old step runs to the wrap, then step of 512.
    do_reset();
    cycle(0, 1, 1, 32'h4000_0000, 10'd0, 2'd0);
    idle_run(2);
    cycle(0, 1, 1, 32'h8000_0000, 10'd0, 2'd0);
    chk("pend_ready", bus.cfg_ready, 0);
    chk("pend_addr", bus.addr, 512);
    idle_run(1);
    chk("swap_addr", bus.addr, 768);
    chk("swap_ready", bus.cfg_ready, 1);
    idle_run(1);
    chk("new_step0", bus.addr, 0);
    idle_run(1);
    chk("new_step1", bus.addr, 512);

    // Zero step: pending config taken on the next enabled edge.
    do_reset();
    cycle(0, 1, 1, 32'h0, 10'd0, 2'd0);
    idle_run(1);
    cycle(0, 1, 1, 32'h4000_0000, 10'd0, 2'd0);
    chk("zero_pend_ready", bus.cfg_ready, 0);
    idle_run(1);
    chk("zero_swap_ready", bus.cfg_ready, 1);
    for (int k = 0; k < 3; k++) begin
      idle_run(1);
      chk("zero_after_addr", bus.addr, k * 256);
    end

    // Enable low for three cycles mid-run.
    idle_run(1);
    held = bus.addr;
    for (int k = 0; k < 3; k++) begin
      cycle(0, 0, 0, 32'h0, 10'd0, 2'd0);
      chk("frozen_addr", bus.addr, held);
      chk("frozen_valid", bus.addr_valid, 0);
    end
    idle_run(1);
    chk("resume_addr", bus.addr, (held + 256) % 1024);

    // Reset while a config is pending.
    cycle(0, 1, 1, 32'h8000_0000, 10'd5, 2'd2);
    chk("pend2_ready", bus.cfg_ready, 0);
    do_reset();
    chk("rst_pend_addr", bus.addr, 0);
    chk("rst_pend_valid", bus.addr_valid, 0);
    chk("rst_pend_ready", bus.cfg_ready, 1);
    idle_run(4);
    chk("shadow_dropped", bus.addr_valid, 0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      bit          r, e, v;
      logic [31:0] f;
      r = ($urandom_range(0, 99) < 2);
      e = ($urandom_range(0, 9) < 8);
      v = e && ($urandom_range(0, 9) < 2);
      case ($urandom_range(0, 3))
        0:       f = 32'h0;
        1:       f = $urandom_range(1, 15) << 28;
        default: f = $urandom;
      endcase
      cycle(r, e, v, f, 10'($urandom), 2'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
